// File: rtl/d_fifo_drain.sv
// d_fifo_drain: round-robin drain of destination FIFOs D0/D1 into one tagged valid/ready stream
// Ports: clk/reset (async, active-high); enable gates new pops; empty_D*/data_out_D*/D*_pop
// form the FIFO read side (data valid the cycle after a pop); out_valid/out_ready/out_data/out_dest
// form the output stream; cnt_D* are saturating delivered counts, cleared by clear_counts; idle = FSM in IDLE.
module d_fifo_drain #(
    parameter int data_width = 6,
    parameter int cnt_width  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_D0,
    input  logic                  empty_D1,
    input  logic [data_width-1:0] data_out_D0,
    input  logic [data_width-1:0] data_out_D1,
    output logic                  D0_pop,
    output logic                  D1_pop,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    output logic                  out_dest,
    output logic [cnt_width-1:0]  cnt_D0,
    output logic [cnt_width-1:0]  cnt_D1,
    input  logic                  clear_counts,
    output logic                  idle
);
    typedef enum logic [1:0] {IDLE, POP, WAIT, HOLD} state_t;
    state_t state, state_n;
    logic sel, last, arb, hs, start;
    always_comb begin
        // both ready: take the one not served last; otherwise the only non-empty one
        arb     = (!empty_D0 && !empty_D1) ? ~last : empty_D0;
        hs      = out_valid && out_ready;
        start   = enable && (!empty_D0 || !empty_D1) && (state == IDLE || (state == HOLD && hs));
        state_n = state;
        case (state)
            IDLE:    state_n = start ? POP : IDLE;
            POP:     state_n = WAIT;
            WAIT:    state_n = HOLD;
            HOLD:    state_n = start ? POP : (hs ? IDLE : HOLD);
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            D0_pop    <= 1'b0;
            D1_pop    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= 1'b0;
            cnt_D0    <= '0;
            cnt_D1    <= '0;
        end else begin
            state  <= state_n;
            D0_pop <= start && !arb;
            D1_pop <= start && arb;
            if (start)
                sel <= arb;
            if (state == WAIT) begin
                out_data  <= sel ? data_out_D1 : data_out_D0;
                out_dest  <= sel;
                out_valid <= 1'b1;
                last      <= sel;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            if (clear_counts) begin
                cnt_D0 <= '0;
                cnt_D1 <= '0;
            end else if (hs) begin
                if (!out_dest && cnt_D0 != '1)
                    cnt_D0 <= cnt_D0 + 1'b1;
                if (out_dest && cnt_D1 != '1)
                    cnt_D1 <= cnt_D1 + 1'b1;
            end
        end
    end
    assign idle = (state == IDLE);
endmodule

// File: tb/tb_d_fifo_drain.sv
// tb_d_fifo_drain: directed bench for d_fifo_drain with behavioural D0/D1 FIFOs
// Ports: none; drives every d_fifo_drain port and prints one summary line.
module tb_d_fifo_drain;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       out_ready = 1'b0;
    logic       clear_counts = 1'b0;
    logic       empty_D0, empty_D1, D0_pop, D1_pop, out_valid, out_dest, idle;
    logic [5:0] data_out_D0 = '0;
    logic [5:0] data_out_D1 = '0;
    logic [5:0] out_data;
    logic [4:0] cnt_D0, cnt_D1;
    logic [5:0] mem0 [64];
    logic [5:0] mem1 [64];
    int wp0 = 0, wp1 = 0, rp0 = 0, rp1 = 0, bad_pop = 0;
    int checks = 0, errors = 0;

    d_fifo_drain #(.data_width(6), .cnt_width(5)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .empty_D0(empty_D0), .empty_D1(empty_D1),
        .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
        .D0_pop(D0_pop), .D1_pop(D1_pop),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
        .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .clear_counts(clear_counts), .idle(idle)
    );

    always #5 clk = ~clk;

    assign empty_D0 = (wp0 == rp0);
    assign empty_D1 = (wp1 == rp1);

    // FIFO model: read data appears right after the edge that samples the pop
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rp0 <= 0;
            rp1 <= 0;
        end else begin
            if ((D0_pop && wp0 == rp0) || (D1_pop && wp1 == rp1) || (D0_pop && D1_pop))
                bad_pop <= bad_pop + 1;
            if (D0_pop) begin
                data_out_D0 <= mem0[rp0];
                rp0 <= rp0 + 1;
            end
            if (D1_pop) begin
                data_out_D1 <= mem1[rp1];
                rp1 <= rp1 + 1;
            end
        end
    end

    task automatic push0(input logic [5:0] v);
        mem0[wp0] = v;
        wp0 = wp0 + 1;
    endtask

    task automatic push1(input logic [5:0] v);
        mem1[wp1] = v;
        wp1 = wp1 + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wp0 = 0;
        wp1 = 0;
        enable = 1'b0;
        out_ready = 1'b0;
        clear_counts = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({D0_pop, D1_pop, out_valid, out_data, out_dest, cnt_D0, cnt_D1, idle} !== {3'b000, 6'h00, 1'b0, 5'd0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: pops=%b%b valid=%b data=%h dest=%b cnt=%0d/%0d idle=%b required all 0, idle=1",
                     D0_pop, D1_pop, out_valid, out_data, out_dest, cnt_D0, cnt_D1, idle);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        push0(6'h15);
        enable = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({D0_pop, D1_pop, idle} !== 3'b100) begin
            errors++;
            $display("FAIL single_pop: D0_pop=%b D1_pop=%b idle=%b required 1 0 0", D0_pop, D1_pop, idle);
        end
        @(negedge clk);
        checks++;
        if ({D0_pop, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_wait: D0_pop=%b out_valid=%b required 0 0", D0_pop, out_valid);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_data, out_dest, cnt_D0} !== {1'b1, 6'h15, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL single_out: valid=%b data=%h dest=%b cnt_D0=%0d required 1 15 0 0", out_valid, out_data, out_dest, cnt_D0);
        end
        @(negedge clk);
        checks++;
        if ({cnt_D0, out_valid, idle} !== {5'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_count: cnt_D0=%0d valid=%b idle=%b required 1 0 1", cnt_D0, out_valid, idle);
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] ed [6] = '{6'h01, 6'h21, 6'h02, 6'h22, 6'h03, 6'h23};
        int got = 0, last_c = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push0(6'(i + 1));
            push1(6'(6'h21 + i));
        end
        enable = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if ({out_dest, out_data} !== {got[0], ed[got]}) begin
                    errors++;
                    $display("FAIL rr_word%0d: dest=%b data=%h required %b %h", got, out_dest, out_data, got[0], ed[got]);
                end
                if (got > 0) begin
                    checks++;
                    if (c - last_c != 3) begin
                        errors++;
                        $display("FAIL rr_spacing%0d: %0d cycles required 3", got, c - last_c);
                    end
                end
                last_c = c;
                got++;
            end
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL rr_timeout: got %0d words required 6", got);
        end
        @(negedge clk);
        checks++;
        if (cnt_D0 !== 5'd3 || cnt_D1 !== 5'd3 || idle !== 1'b1 || bad_pop != 0) begin
            errors++;
            $display("FAIL rr_final: cnt=%0d/%0d idle=%b bad_pops=%0d required 3/3 1 0", cnt_D0, cnt_D1, idle, bad_pop);
        end
    endtask

    task automatic test_stall();
        do_reset();
        push0(6'h2A);
        push0(6'h2B);
        enable = 1'b1;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_data, D0_pop, D1_pop, cnt_D0} !== {1'b1, 6'h2A, 2'b00, 5'd0}) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b data=%h pops=%b%b cnt_D0=%0d required 1 2a 00 0",
                         i, out_valid, out_data, D0_pop, D1_pop, cnt_D0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({cnt_D0, D0_pop, out_valid} !== {5'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_release: cnt_D0=%0d D0_pop=%b valid=%b required 1 1 0", cnt_D0, D0_pop, out_valid);
        end
        wait_valid("stall_next");
        checks++;
        if (out_data !== 6'h2B) begin
            errors++;
            $display("FAIL stall_next_data: data=%h required 2b", out_data);
        end
        @(negedge clk);
        checks++;
        if (cnt_D0 !== 5'd2) begin
            errors++;
            $display("FAIL stall_count: cnt_D0=%0d required 2", cnt_D0);
        end
    endtask

    task automatic test_enable_drop();
        logic bad = 1'b0;
        do_reset();
        push0(6'h11);
        push0(6'h12);
        enable = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (D0_pop !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_pop: D0_pop=%b required 1", D0_pop);
        end
        enable = 1'b0;
        wait_valid("en_drop");
        checks++;
        if ({out_data, out_dest} !== {6'h11, 1'b0}) begin
            errors++;
            $display("FAIL en_drop_data: data=%h dest=%b required 11 0", out_data, out_dest);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (D0_pop || D1_pop || !idle) bad = 1'b1;
        end
        checks++;
        if (bad || cnt_D0 !== 5'd1 || empty_D0 !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_idle: activity=%b cnt_D0=%0d empty_D0=%b required 0 1 0", bad, cnt_D0, empty_D0);
        end
    endtask

    task automatic test_saturate();
        int got = 0;
        do_reset();
        for (int i = 0; i < 33; i++) push1(6'(i));
        enable = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && got < 33; c++) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        @(negedge clk);
        checks++;
        if (got != 33 || cnt_D1 !== 5'd31 || cnt_D0 !== 5'd0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: words=%0d cnt_D1=%0d cnt_D0=%0d idle=%b required 33 31 0 1", got, cnt_D1, cnt_D0, idle);
        end
        push1(6'h05);
        wait_valid("sat_clear");
        clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        checks++;
        if ({cnt_D1, cnt_D0, out_valid} !== {5'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL clear_wins: cnt_D1=%0d cnt_D0=%0d valid=%b required 0 0 0", cnt_D1, cnt_D0, out_valid);
        end
        @(negedge clk);
        checks++;
        if ({cnt_D1, idle} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL clear_stays: cnt_D1=%0d idle=%b required 0 1", cnt_D1, idle);
        end
    endtask

    task automatic test_async_reset();
        logic bad = 1'b0;
        do_reset();
        push0(6'h33);
        enable = 1'b1;
        wait_valid("async");
        #2;
        reset = 1'b1;
        wp0 = 0;
        wp1 = 0;
        #1;
        checks++;
        if ({out_valid, out_data, out_dest, D0_pop, D1_pop, cnt_D0, cnt_D1, idle} !== {1'b0, 6'h00, 3'b000, 5'd0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: valid=%b data=%h dest=%b pops=%b%b cnt=%0d/%0d idle=%b required all 0, idle=1",
                     out_valid, out_data, out_dest, D0_pop, D1_pop, cnt_D0, cnt_D1, idle);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (D0_pop || D1_pop || !idle) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL async_quiet: activity=%b required 0", bad);
        end
        push0(6'h07);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (D0_pop !== 1'b1) begin
            errors++;
            $display("FAIL async_restart: D0_pop=%b required 1", D0_pop);
        end
        wait_valid("async_restart");
        checks++;
        if (out_data !== 6'h07) begin
            errors++;
            $display("FAIL async_data: data=%h required 07", out_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_enable_drop();
        test_saturate();
        test_async_reset();
        @(negedge clk);
        checks++;
        if (bad_pop != 0) begin
            errors++;
            $display("FAIL pop_when_empty: %0d bad pops required 0", bad_pop);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
